// File: rtl/chan_fifo_bridge_pkg.sv
// Shared constants for chan_fifo_bridge: default channel numbers, status-byte
// layout, flush-bit index and the channel-decode type.
package chan_fifo_bridge_pkg;

  localparam logic [6:0] CHAN_DATA_DEFAULT = 7'd0;
  localparam logic [6:0] CHAN_STAT_DEFAULT = 7'd1;

  localparam int STAT_RX_FULL_BIT  = 7;
  localparam int STAT_TX_EMPTY_BIT = 6;
  localparam int STAT_COUNT_MSB    = 4;
  localparam int FLUSH_BIT         = 0;

  typedef enum logic [1:0] {
    SEL_DATA  = 2'd0,
    SEL_STAT  = 2'd1,
    SEL_OTHER = 2'd2
  } chan_sel_e;

  function automatic logic [7:0] status_byte(input logic       rx_full,
                                             input logic       tx_empty,
                                             input logic [4:0] tx_count);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_RX_FULL_BIT]    = rx_full;
    s[STAT_TX_EMPTY_BIT]   = tx_empty;
    s[STAT_COUNT_MSB:0]    = tx_count;
    return s;
  endfunction

endpackage

// File: rtl/chan_fifo_bridge_fifo.sv
// First-word-fall-through synchronous FIFO with flush; a push is refused when
// full even if a pop happens in the same cycle.
module fifo_sync #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam int                   DEPTH_INT = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  DEPTH     = DEPTH_INT[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]  CNT_ONE   = 1;

  logic [WIDTH-1:0]      mem_r [DEPTH_INT];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_r == DEPTH);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer and occupancy update; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/chan_fifo_bridge.sv
// Bridges a channel-addressed host byte interface to a pair of FIFOs: rx
// (host to processor) and tx (processor to host), plus a status/flush channel.
module chan_fifo_bridge
  import chan_fifo_bridge_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [6:0] CHAN_DATA  = CHAN_DATA_DEFAULT,
  parameter logic [6:0] CHAN_STAT  = CHAN_STAT_DEFAULT
) (
  input  logic       fx2Clk_in,
  input  logic       reset_in,
  input  logic [6:0] chanAddr_in,
  input  logic [7:0] h2fData_in,
  input  logic       h2fValid_in,
  output logic       h2fReady_out,
  output logic [7:0] f2hData_out,
  output logic       f2hValid_out,
  input  logic       f2hReady_in,
  output logic [7:0] rxData_out,
  output logic       rxValid_out,
  input  logic       rxReady_in,
  input  logic [7:0] txData_in,
  input  logic       txValid_in,
  output logic       txReady_out
);

  chan_sel_e           sel_s;
  logic                rx_full_s;
  logic                rx_empty_s;
  logic [DEPTH_LOG2:0] rx_count_s;
  logic                tx_full_s;
  logic                tx_empty_s;
  logic [DEPTH_LOG2:0] tx_count_s;
  logic [7:0]          tx_head_s;
  logic                h2f_ready_s;
  logic [7:0]          f2h_data_s;
  logic                f2h_valid_s;
  logic                rx_push_s;
  logic                rx_pop_s;
  logic                tx_push_s;
  logic                tx_pop_s;
  logic                flush_s;

  // Channel decode.
  always_comb begin
    sel_s = SEL_OTHER;
    if (chanAddr_in == CHAN_DATA) begin
      sel_s = SEL_DATA;
    end else if (chanAddr_in == CHAN_STAT) begin
      sel_s = SEL_STAT;
    end else begin
      sel_s = SEL_OTHER;
    end
  end

  // Host-side ready and read-data mux; unknown channels never stall the host.
  always_comb begin
    h2f_ready_s = 1'b0;
    f2h_data_s  = 8'h00;
    f2h_valid_s = 1'b0;
    case (sel_s)
      SEL_DATA: begin
        h2f_ready_s = !rx_full_s && !reset_in;
        f2h_data_s  = tx_head_s;
        f2h_valid_s = !tx_empty_s;
      end
      SEL_STAT: begin
        h2f_ready_s = !reset_in;
        f2h_data_s  = status_byte(rx_full_s, tx_empty_s, 5'(tx_count_s));
        f2h_valid_s = 1'b1;
      end
      default: begin
        h2f_ready_s = !reset_in;
        f2h_data_s  = 8'h00;
        f2h_valid_s = 1'b1;
      end
    endcase
  end

  assign h2fReady_out = h2f_ready_s;
  assign f2hData_out  = f2h_data_s;
  assign f2hValid_out = f2h_valid_s;
  assign rxValid_out  = !rx_empty_s;
  assign txReady_out  = !tx_full_s && !reset_in;

  assign rx_push_s = (sel_s == SEL_DATA) && h2fValid_in && h2f_ready_s;
  assign tx_pop_s  = (sel_s == SEL_DATA) && f2hReady_in && f2h_valid_s;
  assign flush_s   = (sel_s == SEL_STAT) && h2fValid_in && h2f_ready_s
                     && h2fData_in[FLUSH_BIT];
  assign rx_pop_s  = rxValid_out && rxReady_in;
  assign tx_push_s = txValid_in && txReady_out;

  fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_rx_fifo (
    .clk   (fx2Clk_in),
    .reset (reset_in),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .flush (flush_s),
    .din   (h2fData_in),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s),
    .head  (rxData_out)
  );

  fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_tx_fifo (
    .clk   (fx2Clk_in),
    .reset (reset_in),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .flush (flush_s),
    .din   (txData_in),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s),
    .head  (tx_head_s)
  );

endmodule

// File: tb/tb_chan_fifo_bridge.sv
// Self-checking bench for chan_fifo_bridge: a channel-mux vector table plus
// scoreboarded sequences for the FIFO corner cases.
module tb_chan_fifo_bridge;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic [6:0] chanAddr_in = 7'd0;
  logic [7:0] h2fData_in = 8'h00;
  logic       h2fValid_in = 1'b0;
  logic       h2fReady_out;
  logic [7:0] f2hData_out;
  logic       f2hValid_out;
  logic       f2hReady_in = 1'b0;
  logic [7:0] rxData_out;
  logic       rxValid_out;
  logic       rxReady_in = 1'b0;
  logic [7:0] txData_in = 8'h00;
  logic       txValid_in = 1'b0;
  logic       txReady_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    string      name;
    logic [6:0] chan;
    logic       h2f_valid;
    logic [7:0] h2f_data;
    logic       exp_h2f_ready;
    logic       exp_f2h_valid;
    logic [7:0] exp_f2h_data;
    logic       check_data;
  } vec_t;

  vec_t vecs[6];

  chan_fifo_bridge dut (
    .fx2Clk_in    (clk),
    .reset_in     (reset_in),
    .chanAddr_in  (chanAddr_in),
    .h2fData_in   (h2fData_in),
    .h2fValid_in  (h2fValid_in),
    .h2fReady_out (h2fReady_out),
    .f2hData_out  (f2hData_out),
    .f2hValid_out (f2hValid_out),
    .f2hReady_in  (f2hReady_in),
    .rxData_out   (rxData_out),
    .rxValid_out  (rxValid_out),
    .rxReady_in   (rxReady_in),
    .txData_in    (txData_in),
    .txValid_in   (txValid_in),
    .txReady_out  (txReady_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    logic [4:0] c;
    c = 5'(tx_q.size());
    return {(rx_q.size() == 16), (tx_q.size() == 0), 1'b0, c};
  endfunction

  // Host write with a bounded wait for ready; the model follows the handshake.
  task automatic h2f_write(input logic [6:0] ch, input logic [7:0] d);
    int w;
    w = 0;
    chanAddr_in = ch;
    h2fData_in  = d;
    h2fValid_in = 1'b1;
    #1;
    while (!h2fReady_out && w < 20) begin
      cyc();
      w++;
    end
    check("h2f_ready_wait", h2fReady_out, 1'b1);
    if (h2fReady_out) begin
      if (ch == 7'd0) begin
        rx_q.push_back(d);
      end else if (ch == 7'd1 && d[0]) begin
        rx_q.delete();
        tx_q.delete();
      end
    end
    cyc();
    h2fValid_in = 1'b0;
  endtask

  task automatic rx_pop();
    logic [7:0] e;
    check("rx_valid_before_pop", rxValid_out, 1'b1);
    e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hXX;
    check("rx_data", rxData_out, e);
    rxReady_in = 1'b1;
    cyc();
    rxReady_in = 1'b0;
    #1;
  endtask

  task automatic tx_push(input logic [7:0] d);
    txData_in  = d;
    txValid_in = 1'b1;
    #1;
    check("tx_ready", txReady_out, 1'b1);
    if (txReady_out) tx_q.push_back(d);
    cyc();
    txValid_in = 1'b0;
  endtask

  task automatic f2h_read_data();
    logic [7:0] e;
    chanAddr_in = 7'd0;
    f2hReady_in = 1'b1;
    #1;
    check("f2h_valid_data", f2hValid_out, 1'b1);
    e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hXX;
    check("f2h_data", f2hData_out, e);
    cyc();
    f2hReady_in = 1'b0;
  endtask

  task automatic stat_read(input string name);
    chanAddr_in = 7'd1;
    #1;
    check({name, "_valid"}, f2hValid_out, 1'b1);
    check(name, f2hData_out, exp_status());
  endtask

  initial begin
    vecs[0] = '{"chan0_empty", 7'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{"chan1_status", 7'd1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b1};
    vecs[2] = '{"chan1_write0", 7'd1, 1'b1, 8'hFE, 1'b1, 1'b1, 8'h40, 1'b1};
    vecs[3] = '{"chan5_read", 7'd5, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{"chan2_write", 7'd2, 1'b1, 8'h5C, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{"chan127_read", 7'd127, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};

    // Reset state
    cyc(); cyc();
    check("reset_h2f_ready", h2fReady_out, 1'b0);
    check("reset_tx_ready", txReady_out, 1'b0);
    cyc();
    reset_in = 1'b0;
    #1;
    check("post_rx_valid", rxValid_out, 1'b0);
    check("post_f2h_valid", f2hValid_out, 1'b0);
    check("post_tx_ready", txReady_out, 1'b1);
    check("post_h2f_ready", h2fReady_out, 1'b1);

    // Channel mux table; none of these entries may disturb the empty FIFOs
    for (int i = 0; i < 6; i++) begin
      chanAddr_in = vecs[i].chan;
      h2fValid_in = vecs[i].h2f_valid;
      h2fData_in  = vecs[i].h2f_data;
      #1;
      check({vecs[i].name, "_h2f_ready"}, h2fReady_out, vecs[i].exp_h2f_ready);
      check({vecs[i].name, "_f2h_valid"}, f2hValid_out, vecs[i].exp_f2h_valid);
      if (vecs[i].check_data) check({vecs[i].name, "_f2h_data"}, f2hData_out, vecs[i].exp_f2h_data);
      cyc();
      h2fValid_in = 1'b0;
      #1;
      check({vecs[i].name, "_rx_untouched"}, rxValid_out, 1'b0);
    end

    // Three writes, then pop in order
    h2f_write(7'd0, 8'h11);
    h2f_write(7'd0, 8'h22);
    h2f_write(7'd0, 8'h33);
    #1;
    check("rx_valid_after_writes", rxValid_out, 1'b1);
    check("rx_head_first", rxData_out, 8'h11);
    rx_pop(); rx_pop(); rx_pop();
    check("rx_empty_after_pops", rxValid_out, 1'b0);

    // Fill rx; the 17th byte waits for a pop and is refused in the pop cycle
    for (int i = 0; i < 16; i++) h2f_write(7'd0, 8'(8'h80 + i));
    #1;
    check("rx_full_ready_low", h2fReady_out, 1'b0);
    stat_read("stat_rx_full");
    chanAddr_in = 7'd0;
    h2fData_in  = 8'hEE;
    h2fValid_in = 1'b1;
    cyc();
    check("rx_full_hold", h2fReady_out, 1'b0);
    rxReady_in = 1'b1;
    #1;
    check("rx_full_pop_cycle_ready", h2fReady_out, 1'b0);
    check("rx_full_pop_data", rxData_out, rx_q.pop_front());
    cyc();
    rxReady_in = 1'b0;
    #1;
    check("rx_17th_accept_ready", h2fReady_out, 1'b1);
    if (h2fReady_out) rx_q.push_back(8'hEE);
    cyc();
    h2fValid_in = 1'b0;
    #1;
    while (rx_q.size() > 0) rx_pop();
    check("rx_drained", rxValid_out, 1'b0);

    // tx path and status byte
    tx_push(8'hA5);
    tx_push(8'h5A);
    stat_read("stat_tx2");
    f2h_read_data();
    f2h_read_data();
    stat_read("stat_tx0");
    chanAddr_in = 7'd0;
    #1;
    check("f2h_valid_tx_empty", f2hValid_out, 1'b0);

    // Simultaneous push/pop on rx holding 8 bytes
    for (int i = 0; i < 8; i++) h2f_write(7'd0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      chanAddr_in = 7'd0;
      h2fData_in  = 8'(8'h40 + i);
      h2fValid_in = 1'b1;
      rxReady_in  = 1'b1;
      #1;
      check("pp_ready", h2fReady_out, 1'b1);
      check("pp_head", rxData_out, rx_q.pop_front());
      rx_q.push_back(8'(8'h40 + i));
      cyc();
    end
    h2fValid_in = 1'b0;
    rxReady_in  = 1'b0;
    #1;
    check("pp_rx_count", 8'(rx_q.size()), 8'd8);
    while (rx_q.size() > 0) rx_pop();
    check("pp_rx_exactly_8", rxValid_out, 1'b0);

    // Fill tx, then flush in the same cycle as a tx push attempt
    h2f_write(7'd0, 8'h99);
    for (int i = 0; i < 16; i++) tx_push(8'(8'hC0 + i));
    #1;
    check("tx_full_ready_low", txReady_out, 1'b0);
    stat_read("stat_tx_full");
    txData_in  = 8'h77;
    txValid_in = 1'b1;
    h2f_write(7'd1, 8'h01);
    txValid_in = 1'b0;
    stat_read("stat_after_flush");
    check("flush_tx_ready", txReady_out, 1'b1);
    check("flush_rx_empty", rxValid_out, 1'b0);

    // Unknown channel, then reset with buffered bytes
    chanAddr_in = 7'd5;
    #1;
    check("chan5_valid", f2hValid_out, 1'b1);
    check("chan5_data", f2hData_out, 8'h00);
    for (int i = 0; i < 4; i++) h2f_write(7'd0, 8'(8'h60 + i));
    tx_push(8'h3C);
    #1;
    check("rx_valid_before_reset", rxValid_out, 1'b1);
    reset_in = 1'b1;
    cyc();
    rx_q.delete();
    tx_q.delete();
    check("reset_mid_rx_valid", rxValid_out, 1'b0);
    reset_in = 1'b0;
    chanAddr_in = 7'd0;
    #1;
    check("reset_mid_f2h_valid", f2hValid_out, 1'b0);
    stat_read("stat_after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
